load_store_unit: RTL and testbench

//  Initiator side of the data-memory interface. Accepts one load/store per handshake from the execute stage.

---
 rtl/load_store_unit.sv | 167 ++++++++++++++++
 tb/tb_load_store_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-wide data memory: alignment/range checks,
// load extraction with sign/zero extension, and read-modify-write for partial stores.
//
//  state | meaning
//  IDLE  | ready for a request
//  READ  | one-cycle memory read (load, or first half of a partial store)
//  WRITE | one-cycle memory write of a full word
//  RESP  | response held until resp_ready
module load_store_unit #(
  parameter int XLEN                   = 64,
  parameter int BYTE_SIZE              = 8,
  parameter int MEM_STEPS              = XLEN / BYTE_SIZE,
  parameter int SIMULATION_MEMORY_SIZE = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_write,
  input  logic [2:0]                        req_funct3,
  input  logic [XLEN-1:0]                   req_addr,
  input  logic [XLEN-1:0]                   req_wdata,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [XLEN-1:0]                   resp_rdata,
  output logic                              resp_error,
  output logic                              mem_read_enable,
  output logic                              mem_write_enable,
  output logic [SIMULATION_MEMORY_SIZE-1:0] mem_read_addr,
  output logic [XLEN-1:0]                   mem_write_addr,
  output logic [XLEN-1:0]                   mem_write_data,
  input  logic [XLEN-1:0]                   mem_read_data
);

  localparam int OFF_W  = $clog2(MEM_STEPS);
  localparam int BS_W   = $clog2(BYTE_SIZE);
  localparam int IDX_HI = SIMULATION_MEMORY_SIZE + OFF_W - 1;
  localparam int B_W    = BYTE_SIZE;
  localparam int H_W    = 2 * BYTE_SIZE;
  localparam int W_W    = 4 * BYTE_SIZE;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state, state_nxt;

  logic [OFF_W-1:0]                  req_off, align_mask;
  logic                              req_err;
  logic                              op_write;
  logic [2:0]                        op_funct3;
  logic [OFF_W-1:0]                  op_off;
  logic [SIMULATION_MEMORY_SIZE-1:0] op_idx;
  logic [XLEN-1:0]                   op_wdata, rd_word, resp_rdata_q;
  logic                              resp_error_q;
  logic [OFF_W+BS_W-1:0]             sh;
  logic [XLEN-1:0]                   shifted, load_data, wmask, merged;
  logic [MEM_STEPS-1:0]              size_en, byte_en;

  assign req_off = req_addr[OFF_W-1:0];

  always_comb begin
    align_mask = '0;
    case (req_funct3[1:0])
      2'd0:    align_mask = '0;
      2'd1:    align_mask = OFF_W'(1);
      2'd2:    align_mask = OFF_W'(3);
      default: align_mask = '1;
    endcase
  end

  // The top index bit doubles as the "index >= depth" test.
  assign req_err = (|(req_off & align_mask))
                 || (|req_addr[XLEN-1:IDX_HI])
                 || (req_funct3 == 3'b111)
                 || (req_write && req_funct3[2]);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                                 state_nxt = RESP;
          else if (req_write && req_funct3[1:0] == 2'b11) state_nxt = WRITE;
          else                                         state_nxt = READ;
        end
      end
      READ:    state_nxt = op_write ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign sh      = {op_off, {BS_W{1'b0}}};
  assign shifted = mem_read_data >> sh;

  always_comb begin
    load_data = shifted;
    case (op_funct3)
      3'b000:  load_data = {{(XLEN-B_W){shifted[B_W-1]}}, shifted[B_W-1:0]};
      3'b001:  load_data = {{(XLEN-H_W){shifted[H_W-1]}}, shifted[H_W-1:0]};
      3'b010:  load_data = {{(XLEN-W_W){shifted[W_W-1]}}, shifted[W_W-1:0]};
      3'b100:  load_data = {{(XLEN-B_W){1'b0}}, shifted[B_W-1:0]};
      3'b101:  load_data = {{(XLEN-H_W){1'b0}}, shifted[H_W-1:0]};
      3'b110:  load_data = {{(XLEN-W_W){1'b0}}, shifted[W_W-1:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    size_en = '1;
    case (op_funct3[1:0])
      2'd0:    size_en = MEM_STEPS'(8'h01);
      2'd1:    size_en = MEM_STEPS'(8'h03);
      2'd2:    size_en = MEM_STEPS'(8'h0f);
      default: size_en = '1;
    endcase
    byte_en = size_en << op_off;
    wmask   = '0;
    for (int i = 0; i < MEM_STEPS; i++)
      wmask[i*BYTE_SIZE +: BYTE_SIZE] = {BYTE_SIZE{byte_en[i]}};
  end

  // For SD the mask is all ones, so the stale captured word never leaks through.
  assign merged = (rd_word & ~wmask) | ((op_wdata << sh) & wmask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_write     <= 1'b0;
      op_funct3    <= '0;
      op_off       <= '0;
      op_idx       <= '0;
      op_wdata     <= '0;
      rd_word      <= '0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        op_write     <= req_write;
        op_funct3    <= req_funct3;
        op_off       <= req_off;
        op_idx       <= req_addr[IDX_HI:OFF_W];
        op_wdata     <= req_wdata;
        resp_rdata_q <= '0;
        resp_error_q <= req_err;
      end
      if (state == READ) begin
        rd_word <= mem_read_data;
        if (!op_write) resp_rdata_q <= load_data;
      end
    end
  end

  assign req_ready        = (state == IDLE);
  assign resp_valid       = (state == RESP);
  assign resp_rdata       = resp_rdata_q;
  assign resp_error       = resp_error_q;
  assign mem_read_enable  = (state == READ);
  assign mem_write_enable = (state == WRITE);
  assign mem_read_addr    = (state == READ)  ? op_idx : '0;
  assign mem_write_addr   = (state == WRITE) ? XLEN'(op_idx) : '0;
  assign mem_write_data   = (state == WRITE) ? merged : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed loads/stores/errors/stall/reset, then a
// randomized mix against a byte-addressed reference memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
  logic [2:0]  req_funct3 = '0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_error, mem_read_enable, mem_write_enable;
  logic [63:0] resp_rdata, mem_write_addr, mem_write_data, mem_read_data;
  logic [5:0]  mem_read_addr;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // Simulated dataMemory: combinational read, write on rising edge.
  logic [63:0] mem [32];
  logic        init_we = 1'b0;
  logic [4:0]  init_idx = '0;
  logic [63:0] init_data = '0;
  assign mem_read_data = mem[mem_read_addr[4:0]];
  always @(posedge clk) begin
    if (mem_write_enable)  mem[mem_write_addr[4:0]] <= mem_write_data;
    else if (init_we)      mem[init_idx] <= init_data;
  end

  int both_hi = 0, bad_addr = 0;
  always @(negedge clk) begin
    if (mem_read_enable && mem_write_enable) both_hi++;
    if ((mem_read_enable && mem_read_addr >= 6'd32) ||
        (mem_write_enable && mem_write_addr >= 64'd32)) bad_addr++;
  end

  // Reference model: flat little-endian byte array.
  logic [7:0] ref_b [256];

  function automatic logic [63:0] ref_load(input logic [2:0] f3, input int a);
    int n = 1 << f3[1:0];
    logic [63:0] v = '0;
    for (int i = n - 1; i >= 0; i--) v = (v << 8) | 64'(ref_b[a + i]);
    if (!f3[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  function automatic bit ref_err(input bit w, input logic [2:0] f3, input logic [63:0] a);
    int n = 1 << f3[1:0];
    return (f3 == 3'b111) || (w && f3[2]) || ((a & 64'(n - 1)) != 0) || (a >= 64'd256);
  endfunction

  task automatic ref_store(input logic [2:0] f3, input int a, input logic [63:0] wd);
    int n = 1 << f3[1:0];
    for (int i = 0; i < n; i++) ref_b[a + i] = wd[8*i +: 8];
  endtask

  int n_pass = 0, n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic load_word(input int idx, input logic [63:0] v);
    init_we = 1'b1; init_idx = 5'(idx); init_data = v;
    @(posedge clk); #1;
    init_we = 1'b0;
    for (int b = 0; b < 8; b++) ref_b[idx*8 + b] = v[8*b +: 8];
  endtask

  // lat = samples after the accept edge until resp_valid (1 => visible at T+1).
  task automatic do_req(input bit w, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, input bit hold,
                        output int lat, output logic [63:0] rd, output bit er,
                        output int rdc, output int wrc,
                        output logic [63:0] wa, output logic [63:0] wdt);
    int guard = 0;
    while (!req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; rdc = 0; wrc = 0; wa = '0; wdt = '0;
    while (!resp_valid && lat < 20) begin
      if (mem_read_enable) rdc = lat;
      if (mem_write_enable) begin wrc = lat; wa = mem_write_addr; wdt = mem_write_data; end
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata; er = resp_error;
    if (!hold) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rdc, wrc;
    logic [63:0] rd, wa, wdt, exp_rd;
    bit er, w, e;
    logic [2:0] f3;
    logic [63:0] a, wd;
    int n, mode, exp_lat, exp_rdc, exp_wrc;

    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_error", resp_error, 0);
    chk("rst_strobes", {mem_read_enable, mem_write_enable}, 0);
    chk("rst_addrs", {mem_read_addr, mem_write_addr}, 0);
    chk("rst_wdata", mem_write_data, 0);

    for (int i = 0; i < 32; i++) load_word(i, {$urandom, $urandom});
    load_word(0, 64'h8877665544332211);
    load_word(1, 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed loads
    do_req(0, 3'b000, 64'h7, 0, 0, lat, rd, er, rdc, wrc, wa, wdt);
    chk("lb_data", rd, 64'hFFFFFFFFFFFFFF88);
    chk("lb_lat", lat, 2);
    chk("lb_readcyc", rdc, 1);
    do_req(0, 3'b100, 64'h7, 0, 0, lat, rd, er, rdc, wrc, wa, wdt);
    chk("lbu_data", rd, 64'h88);
    do_req(0, 3'b010, 64'h4, 0, 0, lat, rd, er, rdc, wrc, wa, wdt);
    chk("lw_data", rd, 64'hFFFFFFFF88776655);
    do_req(0, 3'b011, 64'h0, 0, 0, lat, rd, er, rdc, wrc, wa, wdt);
    chk("ld_data", rd, 64'h8877665544332211);
    chk("ld_err", er, 0);

    // Partial store read-modify-write
    do_req(1, 3'b001, 64'h0A, 64'hBEEF, 0, lat, rd, er, rdc, wrc, wa, wdt);
    ref_store(3'b001, 'h0A, 64'hBEEF);
    chk("sh_readcyc", rdc, 1);
    chk("sh_writecyc", wrc, 2);
    chk("sh_waddr", wa, 1);
    chk("sh_wdata", wdt, 64'h00000000BEEF0000);
    chk("sh_lat", lat, 3);
    chk("sh_rdata", rd, 0);
    chk("sh_mem", mem[1], 64'h00000000BEEF0000);

    // Errors
    do_req(0, 3'b010, 64'h6, 0, 0, lat, rd, er, rdc, wrc, wa, wdt);
    chk("misalign_err", er, 1);
    chk("misalign_lat", lat, 1);
    chk("misalign_strobe", rdc + wrc, 0);
    do_req(0, 3'b011, 64'h100, 0, 0, lat, rd, er, rdc, wrc, wa, wdt);
    chk("range_err", er, 1);
    chk("range_lat", lat, 1);
    chk("range_strobe", rdc + wrc, 0);
    do_req(1, 3'b100, 64'h8, 64'h55, 0, lat, rd, er, rdc, wrc, wa, wdt);
    chk("illegal_err", er, 1);
    chk("illegal_lat", lat, 1);
    chk("illegal_strobe", rdc + wrc, 0);
    chk("illegal_rdata", rd, 0);

    // Response stall with a pending request held by the requester
    resp_ready = 1'b0;
    do_req(0, 3'b011, 64'h0, 0, 1, lat, rd, er, rdc, wrc, wa, wdt);
    exp_rd = ref_load(3'b011, 0);
    chk("stall_first", rd, exp_rd);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b011; req_addr = 64'h8;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", resp_valid, 1);
      chk("stall_rdata", resp_rdata, exp_rd);
      chk("stall_ready", req_ready, 0);
      chk("stall_nomem", mem_read_enable, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_ready", req_ready, 1);
    chk("release_valid", resp_valid, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_read", mem_read_enable, 1);
    chk("b2b_raddr", mem_read_addr, 1);
    @(posedge clk); #1;
    chk("b2b_valid", resp_valid, 1);
    chk("b2b_rdata", resp_rdata, ref_load(3'b011, 8));
    @(posedge clk); #1;

    // Reset during WRITE of an SD
    wd = mem[3];
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b011; req_addr = 64'h18;
    req_wdata = 64'hDEADBEEFCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstw_we_before", mem_write_enable, 1);
    rst = 1'b1;
    #1;
    chk("rstw_we_after", mem_write_enable, 0);
    chk("rstw_valid", resp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstw_ready", req_ready, 1);
    chk("rstw_valid_rel", resp_valid, 0);
    chk("rstw_mem", mem[3], wd);
    @(posedge clk); #1;

    // Randomized mix
    for (int k = 0; k < 150; k++) begin
      w = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      n = 1 << f3[1:0];
      mode = $urandom_range(0, 9);
      if (mode == 0)      a = {32'($urandom_range(0, 1)), 32'($urandom_range(256, 2047))};
      else begin
        a = 64'($urandom_range(0, 255));
        if (mode < 8) a = a & ~64'(n - 1);
      end
      wd = {$urandom, $urandom};
      e = ref_err(w, f3, a);
      exp_rd = (e || w) ? 64'h0 : ref_load(f3, int'(a));
      exp_lat = e ? 1 : (w && f3 != 3'b011) ? 3 : 2;
      exp_rdc = (e || (w && f3 == 3'b011)) ? 0 : 1;
      exp_wrc = (e || !w) ? 0 : (f3 == 3'b011) ? 1 : 2;
      do_req(w, f3, a, wd, 0, lat, rd, er, rdc, wrc, wa, wdt);
      if (w && !e) ref_store(f3, int'(a), wd);
      chk("rnd_err", er, e);
      chk("rnd_rdata", rd, exp_rd);
      chk("rnd_lat", lat, exp_lat);
      chk("rnd_readcyc", rdc, exp_rdc);
      chk("rnd_writecyc", wrc, exp_wrc);
    end

    for (int i = 0; i < 32; i++) begin
      wd = '0;
      for (int b = 7; b >= 0; b--) wd = (wd << 8) | 64'(ref_b[i*8 + b]);
      chk("final_mem", mem[i], wd);
    end
    chk("no_dual_strobe", both_hi, 0);
    chk("no_bad_addr", bad_addr, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
